// File: rtl/clock_group_reset_sequencer.sv
// rtl/clock_group_reset_sequencer.sv - power-on and software re-reset sequencing of clock-group member resets
`timescale 1ns/1ps
module clock_group_reset_sequencer #(
    parameter int NUM_MEMBERS    = 2,
    parameter int SYNC_STAGES    = 3,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4,
    parameter int CNT_W          = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   io_req_valid,
    input  logic [NUM_MEMBERS-1:0] io_req_mask,
    output logic                   io_req_ready,
    output logic [NUM_MEMBERS-1:0] io_member_reset,
    output logic                   io_all_released,
    output logic [1:0]             io_state
);

    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

    localparam int HOLD_LAST = HOLD_CYCLES - 1;
    localparam int REL_LAST  = (NUM_MEMBERS - 1) * STAGGER_CYCLES;
    localparam int CNT_MAX   = (HOLD_LAST > REL_LAST) ? HOLD_LAST : REL_LAST;
    localparam bit CFG_OK    = (CNT_MAX >> CNT_W) == 0;

    state_e                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   sync_q, sync_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [NUM_MEMBERS-1:0]   mrst_q, mrst_d;
    logic [NUM_MEMBERS-1:0]   active_q, active_d;
    logic                     rst_sync;
    logic                     hold_done;
    logic                     rel_done;
    logic                     accept;

    // Zeros shift in after raw reset drops; the last stage is the synchronised reset.
    assign sync_d    = {sync_q[SYNC_STAGES-2:0], 1'b0};
    assign rst_sync  = sync_q[SYNC_STAGES-1];
    assign hold_done = (cnt_q == CNT_W'(HOLD_LAST));
    assign rel_done  = (cnt_q == CNT_W'(REL_LAST));
    assign accept    = (state_q == ST_RUN) && io_req_valid && (|io_req_mask);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_SYNC:    if (!rst_sync) state_d = ST_HOLD;
            ST_HOLD:    if (hold_done) state_d = ST_RELEASE;
            ST_RELEASE: if (rel_done)  state_d = ST_RUN;
            ST_RUN:     if (accept)    state_d = ST_HOLD;
            default:                   state_d = ST_SYNC;
        endcase
    end

    always_comb begin
        io_state        = state_q;
        io_req_ready    = (state_q == ST_RUN);
        io_all_released = (state_q == ST_RUN);
    end

    always_comb begin
        cnt_d    = cnt_q;
        mrst_d   = mrst_q;
        active_d = active_q;
        unique case (state_q)
            ST_SYNC: cnt_d = '0;
            ST_HOLD: cnt_d = hold_done ? '0 : cnt_q + CNT_W'(1);
            ST_RELEASE: begin
                // Release slots are fixed by member index; untargeted members keep their value.
                for (int i = 0; i < NUM_MEMBERS; i++) begin
                    if (active_q[i] && (cnt_q == CNT_W'(i * STAGGER_CYCLES))) begin
                        mrst_d[i] = 1'b0;
                    end
                end
                cnt_d = rel_done ? '0 : cnt_q + CNT_W'(1);
            end
            ST_RUN: begin
                if (accept) begin
                    active_d = io_req_mask;
                    mrst_d   = mrst_q | io_req_mask;
                    cnt_d    = '0;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q   <= '1;
            cnt_q    <= '0;
            mrst_q   <= '1;
            active_q <= '1;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            mrst_q   <= mrst_d;
            active_q <= active_d;
        end
    end

    assign io_member_reset = mrst_q;

    // Counter width must cover the longest hold or stagger count.
    assert property (@(posedge clock) CFG_OK);

endmodule

// File: tb/tb_clock_group_reset_sequencer.sv
// tb/tb_clock_group_reset_sequencer.sv - self-checking bench for clock_group_reset_sequencer
`timescale 1ns/1ps
module tb_clock_group_reset_sequencer;

    localparam int A_N = 2, A_S = 3, A_H = 16, A_ST = 4;
    localparam int B_N = 4, B_S = 2, B_H = 3,  B_ST = 0;
    localparam int A_R = A_H + 1 + (A_N - 1) * A_ST;
    localparam int B_R = B_H + 1 + (B_N - 1) * B_ST;
    localparam int K_CAP = 1 << 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_a = 1'b0, valid_b = 1'b0;
    logic [1:0] mask_a = '0;
    logic [3:0] mask_b = '0;
    logic       ready_a, ready_b, allrel_a, allrel_b;
    logic [1:0] mrst_a, state_a, state_b;
    logic [3:0] mrst_b;

    int checks = 0;
    int errors = 0;

    // Model: k = edges since the current hold phase began (negative while synchronising).
    int         ka = -(A_S + 1);
    int         kb = -(B_S + 1);
    logic [3:0] ma = 4'b0011;
    logic [3:0] mb = 4'b1111;

    clock_group_reset_sequencer #(
        .NUM_MEMBERS(A_N), .SYNC_STAGES(A_S), .HOLD_CYCLES(A_H), .STAGGER_CYCLES(A_ST), .CNT_W(8)
    ) u_dut_a (
        .clock(clk), .reset(rst), .io_req_valid(valid_a), .io_req_mask(mask_a),
        .io_req_ready(ready_a), .io_member_reset(mrst_a), .io_all_released(allrel_a),
        .io_state(state_a)
    );

    clock_group_reset_sequencer #(
        .NUM_MEMBERS(B_N), .SYNC_STAGES(B_S), .HOLD_CYCLES(B_H), .STAGGER_CYCLES(B_ST), .CNT_W(4)
    ) u_dut_b (
        .clock(clk), .reset(rst), .io_req_valid(valid_b), .io_req_mask(mask_b),
        .io_req_ready(ready_b), .io_member_reset(mrst_b), .io_all_released(allrel_b),
        .io_state(state_b)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] exp_state(input int k, input int h, input int r);
        if (k < 0)      return 2'd0;
        else if (k < h) return 2'd1;
        else if (k < r) return 2'd2;
        else            return 2'd3;
    endfunction

    function automatic logic [3:0] exp_mrst(input int k, input logic [3:0] m,
                                            input int n, input int h, input int st);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = m[i] && (k < h + 1 + i * st);
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ka = -(A_S + 1); ma = 4'b0011;
            kb = -(B_S + 1); mb = 4'b1111;
        end else begin
            if (ka >= A_R && valid_a && mask_a != 2'b00) begin
                ka = 0; ma = {2'b00, mask_a};
            end else if (ka < K_CAP) ka++;
            if (kb >= B_R && valid_b && mask_b != 4'b0000) begin
                kb = 0; mb = mask_b;
            end else if (kb < K_CAP) kb++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        logic [3:0] ea, eb;
        logic [1:0] sa, sb;
        ea = exp_mrst(ka, ma, A_N, A_H, A_ST);
        eb = exp_mrst(kb, mb, B_N, B_H, B_ST);
        sa = exp_state(ka, A_H, A_R);
        sb = exp_state(kb, B_H, B_R);
        check("a_state",  state_a,  sa);
        check("a_mrst",   mrst_a,   ea[1:0]);
        check("a_ready",  ready_a,  sa == 2'd3);
        check("a_allrel", allrel_a, sa == 2'd3);
        check("b_state",  state_b,  sb);
        check("b_mrst",   mrst_b,   eb);
        check("b_ready",  ready_b,  sb == 2'd3);
        check("b_allrel", allrel_b, sb == 2'd3);
    endtask

    always @(negedge clk) compare_all();

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_mrst", mrst_a, 2'b11);
        check("rst_a_state", state_a, 2'd0);
        check("rst_a_ready", ready_a, 1'b0);
        check("rst_b_mrst", mrst_b, 4'hF);
        rst = 1'b0;

        // Power-on
        step(4);  check("po_hold", state_a, 2'd1);
        step(17); check("po_e21_mrst", mrst_a, 2'b10); check("po_e21_state", state_a, 2'd2);
        step(4);  check("po_e25_mrst", mrst_a, 2'b00); check("po_e25_state", state_a, 2'd3);
                  check("po_e25_allrel", allrel_a, 1'b1);

        // Empty-mask request is a no-op
        valid_a = 1'b1; mask_a = 2'b00;
        step(1);  check("m0_state", state_a, 2'd3); check("m0_mrst", mrst_a, 2'b00);

        // Re-reset member 1, then a request held through the sequence
        mask_a = 2'b10;
        step(1);  check("rr_ready", ready_a, 1'b0); check("rr_mrst", mrst_a, 2'b10);
        mask_a = 2'b01;
        step(20); check("rr_k20_mrst", mrst_a, 2'b10); check("rr_k20_state", state_a, 2'd2);
        step(1);  check("rr_k21_mrst", mrst_a, 2'b00); check("rr_k21_state", state_a, 2'd3);
        step(1);  check("held_acc_state", state_a, 2'd1); check("held_acc_mrst", mrst_a, 2'b01);
        valid_a = 1'b0;
        step(21); check("held_done_state", state_a, 2'd3); check("held_done_mrst", mrst_a, 2'b00);

        // Async reset from RUN
        rst = 1'b1; #1;
        check("async_mrst", mrst_a, 2'b11); check("async_allrel", allrel_a, 1'b0);
        check("async_state", state_a, 2'd0);
        compare_all();
        #1 rst = 1'b0;
        step(4);  check("po2_hold", state_a, 2'd1);
        step(21); check("po2_mrst", mrst_a, 2'b00); check("po2_state", state_a, 2'd3);

        // Reset during RELEASE with member 0 already released
        rst = 1'b1; #1 rst = 1'b0;
        step(22); check("rel_mid_mrst", mrst_a, 2'b10); check("rel_mid_state", state_a, 2'd2);
        rst = 1'b1; #1;
        check("rel_rst_mrst", mrst_a, 2'b11); check("rel_rst_state", state_a, 2'd0);
        #1 rst = 1'b0;
        step(24); check("po3_e24_mrst", mrst_a, 2'b10);
        step(1);  check("po3_e25_mrst", mrst_a, 2'b00); check("po3_e25_state", state_a, 2'd3);

        // Zero-stagger instance re-reset
        valid_b = 1'b1; mask_b = 4'b0101;
        step(1);  check("b_acc_state", state_b, 2'd1); check("b_acc_mrst", mrst_b, 4'b0101);
        valid_b = 1'b0;
        step(3);  check("b_rel_state", state_b, 2'd2); check("b_rel_mrst", mrst_b, 4'b0101);
        step(1);  check("b_run_state", state_b, 2'd3); check("b_run_mrst", mrst_b, 4'b0000);

        // Randomised traffic with occasional async resets
        for (int c = 0; c < 4000; c++) begin
            valid_a = ($urandom_range(0, 3) == 0);
            mask_a  = 2'($urandom_range(0, 3));
            valid_b = ($urandom_range(0, 3) == 0);
            mask_b  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1; #1;
                compare_all();
                #1 rst = 1'b0;
            end
            step(1);
        end
        valid_a = 1'b0; valid_b = 1'b0;
        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
